// File: rtl/branch_target_predictor_pkg.sv
// Shared CPU package for the fetch-side branch predictor.
//   WORD_SIZE          : PC / instruction width (word-addressed PC)
//   CTR_SNT..CTR_ST    : 2-bit direction counter encodings
//   btb_entry_t        : one BTB entry (valid, tag, target, optional ctr)
// Optional feature macro: BRANCH_COUNTER_EN (adds per-entry 2-bit counters).
package branch_target_predictor_pkg;

  localparam int WORD_SIZE = 16;

  localparam logic [1:0] CTR_SNT = 2'b00;
  localparam logic [1:0] CTR_WNT = 2'b01;
  localparam logic [1:0] CTR_WT  = 2'b10;
  localparam logic [1:0] CTR_ST  = 2'b11;

  // The tag field is WORD_SIZE wide and holds PC >> INDEX_BITS, zero-extended.
  // That keeps the entry type independent of the BTB index width.
  typedef struct packed {
    logic                 valid;
    logic [WORD_SIZE-1:0] tag;
    logic [WORD_SIZE-1:0] target;
`ifdef BRANCH_COUNTER_EN
    logic [1:0]           ctr;
`endif
  } btb_entry_t;

endpackage

// File: rtl/branch_target_predictor_sat_counter2.sv
// 2-bit saturating counter next-state function.
//   ctr      in  2  current counter value
//   inc      in  1  count up (saturates at CTR_ST)
//   dec      in  1  count down (saturates at CTR_SNT)
//   ctr_next out 2  next counter value
// Used only when BRANCH_COUNTER_EN is defined.
module sat_counter2
  import branch_target_predictor_pkg::*;
(
  input  logic [1:0] ctr,
  input  logic       inc,
  input  logic       dec,
  output logic [1:0] ctr_next
);

  always_comb begin
    ctr_next = ctr;
    if (inc && !dec) begin
      if (ctr != CTR_ST) ctr_next = ctr + 2'd1;
    end else if (dec && !inc) begin
      if (ctr != CTR_SNT) ctr_next = ctr - 2'd1;
    end
  end

endmodule

// File: rtl/branch_target_predictor.sv
// Fetch-side branch predictor: direct-mapped BTB with optional 2-bit
// direction counters and a post-reset table-clear sequencer.
//   clk              in   1          clock, rising edge
//   reset            in   1          synchronous, active-high
//   PC               in   WORD_SIZE  current fetch PC
//   predicted_nextPC out  WORD_SIZE  predicted next fetch PC
//   ready            out  1          high once the table clear has finished
//   update_en        in   1          ID stage resolved a control transfer
//   update_PC        in   WORD_SIZE  PC of the resolved instruction
//   update_target    in   WORD_SIZE  resolved jump target
//   update_taken     in   1          resolved direction
//   update_uncond    in   1          unconditional jump
// Optional feature macro: BRANCH_COUNTER_EN. When undefined the BTB is an
// always-taken predictor with no counter storage.
module branch_target_predictor #(
  parameter int WORD_SIZE  = branch_target_predictor_pkg::WORD_SIZE,
  parameter int INDEX_BITS = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_SIZE-1:0] PC,
  output logic [WORD_SIZE-1:0] predicted_nextPC,
  output logic                 ready,
  input  logic                 update_en,
  input  logic [WORD_SIZE-1:0] update_PC,
  input  logic [WORD_SIZE-1:0] update_target,
  input  logic                 update_taken,
  input  logic                 update_uncond
);

  import branch_target_predictor_pkg::*;

  localparam int ENTRIES = 1 << INDEX_BITS;

  if (WORD_SIZE != branch_target_predictor_pkg::WORD_SIZE) begin : g_word_size_check
    $error("WORD_SIZE must match the CPU package WORD_SIZE");
  end
  if (INDEX_BITS >= WORD_SIZE) begin : g_index_bits_check
    $error("INDEX_BITS must be smaller than WORD_SIZE");
  end

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

  state_t                state, state_next;
  logic [INDEX_BITS-1:0] clr_idx, clr_idx_next;

  btb_entry_t btb [ENTRIES];

  // ---------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_idx <= '0;
    end else begin
      state   <= state_next;
      clr_idx <= clr_idx_next;
    end
  end

  always_comb begin
    state_next   = state;
    clr_idx_next = clr_idx;
    ready        = 1'b0;
    case (state)
      CLEAR: begin
        clr_idx_next = clr_idx + 1'b1;
        if (clr_idx == '1) state_next = RUN;
      end
      RUN: begin
        ready = 1'b1;
      end
      default: state_next = CLEAR;
    endcase
  end

  // ---------------------------------------------------------------
  // Prediction (asynchronous table read)
  // ---------------------------------------------------------------
  logic [INDEX_BITS-1:0] pred_idx;
  logic [WORD_SIZE-1:0]  pred_tag;
  btb_entry_t            pred_entry;
  logic                  pred_hit;
  logic                  pred_taken;

  assign pred_idx   = PC[INDEX_BITS-1:0];
  assign pred_tag   = PC >> INDEX_BITS;
  assign pred_entry = btb[pred_idx];
  assign pred_hit   = pred_entry.valid && (pred_entry.tag == pred_tag);

`ifdef BRANCH_COUNTER_EN
  assign pred_taken = pred_hit && pred_entry.ctr[1];
`else
  assign pred_taken = pred_hit;
`endif

  assign predicted_nextPC = (state == RUN && pred_taken) ? pred_entry.target
                                                         : PC + WORD_SIZE'(1);

  // ---------------------------------------------------------------
  // Update path
  // ---------------------------------------------------------------
  logic [INDEX_BITS-1:0] upd_idx;
  logic [WORD_SIZE-1:0]  upd_tag;
  btb_entry_t            upd_cur;
  btb_entry_t            upd_entry;
  logic                  upd_hit;
  logic                  upd_we;

  assign upd_idx = update_PC[INDEX_BITS-1:0];
  assign upd_tag = update_PC >> INDEX_BITS;
  assign upd_cur = btb[upd_idx];
  assign upd_hit = upd_cur.valid && (upd_cur.tag == upd_tag);

`ifdef BRANCH_COUNTER_EN
  logic [1:0] ctr_next;

  sat_counter2 u_sat_counter2 (
    .ctr      (upd_cur.ctr),
    .inc      (update_taken),
    .dec      (!update_taken),
    .ctr_next (ctr_next)
  );

  always_comb begin
    upd_entry = upd_cur;
    upd_we    = 1'b0;
    if (upd_hit) begin
      upd_we = 1'b1;
      if (update_uncond) begin
        upd_entry.target = update_target;
        upd_entry.ctr    = CTR_ST;
      end else begin
        if (update_taken) upd_entry.target = update_target;
        upd_entry.ctr = ctr_next;
      end
    end else if (update_taken) begin
      upd_we           = 1'b1;
      upd_entry.valid  = 1'b1;
      upd_entry.tag    = upd_tag;
      upd_entry.target = update_target;
      upd_entry.ctr    = update_uncond ? CTR_ST : CTR_WT;
    end
  end
`else
  always_comb begin
    upd_entry = upd_cur;
    upd_we    = 1'b0;
    if (update_taken || update_uncond) begin
      upd_we           = 1'b1;
      upd_entry.valid  = 1'b1;
      upd_entry.tag    = upd_tag;
      upd_entry.target = update_target;
    end else if (upd_hit) begin
      upd_we          = 1'b1;
      upd_entry.valid = 1'b0;
    end
  end
`endif

  // Table storage has no reset; the CLEAR sequence invalidates it instead.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (state == CLEAR) begin
        btb[clr_idx].valid <= 1'b0;
      end else if (update_en && upd_we) begin
        btb[upd_idx] <= upd_entry;
      end
    end
  end

endmodule

// File: tb/tb_branch_target_predictor.sv
// Directed self-checking bench for branch_target_predictor.
// Expectations that differ between the counter and always-taken builds are
// selected with BRANCH_COUNTER_EN.
module tb_branch_target_predictor;

  logic        clk;
  logic        reset;
  logic [15:0] PC;
  logic [15:0] predicted_nextPC;
  logic        ready;
  logic        update_en;
  logic [15:0] update_PC;
  logic [15:0] update_target;
  logic        update_taken;
  logic        update_uncond;

  int tests_run;
  int tests_failed;

  branch_target_predictor #(
    .WORD_SIZE  (16),
    .INDEX_BITS (8)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .PC               (PC),
    .predicted_nextPC (predicted_nextPC),
    .ready            (ready),
    .update_en        (update_en),
    .update_PC        (update_PC),
    .update_target    (update_target),
    .update_taken     (update_taken),
    .update_uncond    (update_uncond)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
    end
  endtask

  // Drive a one-cycle update from a negedge; returns 1ns after the posedge.
  task automatic do_update(input logic [15:0] pc, input logic [15:0] tgt,
                           input logic taken, input logic uncond);
    @(negedge clk);
    update_en     = 1'b1;
    update_PC     = pc;
    update_target = tgt;
    update_taken  = taken;
    update_uncond = uncond;
    @(posedge clk);
    #1;
    update_en = 1'b0;
  endtask

  task automatic predict(input string tag, input logic [15:0] pc, input logic [15:0] exp);
    PC = pc;
    #1;
    check_eq(tag, predicted_nextPC, exp);
  endtask

  // Counts posedges until ready, starting from a given count, bounded.
  task automatic wait_ready(input int start, output int cycles);
    cycles = start;
    while (!ready && cycles < 1000) begin
      @(posedge clk);
      #1;
      cycles++;
    end
  endtask

  // Restart via reset; during the first CLEAR cycle an update for 0x0030 is
  // presented and must be ignored. Returns cycles until ready.
  task automatic reset_and_clear(input string tag, output int cycles);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_eq({tag, "_ready_low"}, {15'd0, ready}, 16'h0000);
    predict({tag, "_clear_pred"}, 16'h0010, 16'h0011);
    update_en     = 1'b1;
    update_PC     = 16'h0030;
    update_target = 16'h0099;
    update_taken  = 1'b1;
    update_uncond = 1'b1;
    @(posedge clk);
    #1;
    update_en = 1'b0;
    check_eq({tag, "_ready_c1"}, {15'd0, ready}, 16'h0000);
    wait_ready(1, cycles);
  endtask

  int cyc;

  initial begin
    tests_run     = 0;
    tests_failed  = 0;
    reset         = 1'b1;
    PC            = 16'h0000;
    update_en     = 1'b0;
    update_PC     = 16'h0000;
    update_target = 16'h0000;
    update_taken  = 1'b0;
    update_uncond = 1'b0;
    repeat (2) @(posedge clk);

    // Initial clear: ready rises exactly 256 cycles after reset deasserts.
    reset_and_clear("rst", cyc);
    check_eq("clear_latency", 16'(cyc), 16'd256);
    predict("ignored_clear_upd", 16'h0030, 16'h0031);

    // Conditional taken allocate -> weak-taken, predicts target.
    predict("miss_0020", 16'h0020, 16'h0021);
    do_update(16'h0020, 16'h0040, 1'b1, 1'b0);
    predict("alloc_0020", 16'h0020, 16'h0040);

    // Not-taken training down to strong-NT, then saturation.
    do_update(16'h0020, 16'h0040, 1'b0, 1'b0);
    predict("nt1_0020", 16'h0020, 16'h0021);
    do_update(16'h0020, 16'h0040, 1'b0, 1'b0);
    predict("nt2_0020", 16'h0020, 16'h0021);
    do_update(16'h0020, 16'h0040, 1'b0, 1'b0);
    predict("nt3_0020", 16'h0020, 16'h0021);
    // One taken: counter 00 -> 01 still predicts fall-through;
    // the always-taken BTB re-allocates instead.
    do_update(16'h0020, 16'h0044, 1'b1, 1'b0);
`ifdef BRANCH_COUNTER_EN
    predict("sat_low_0020", 16'h0020, 16'h0021);
`else
    predict("sat_low_0020", 16'h0020, 16'h0044);
`endif

    // Aliasing: 0x0120 shares index 0x20 with a different tag.
    do_update(16'h0120, 16'h0200, 1'b1, 1'b0);
    predict("alias_0020_miss", 16'h0020, 16'h0021);
    predict("alias_0120_hit", 16'h0120, 16'h0200);

    // Wrap on fall-through, then unconditional allocate.
    predict("wrap_ffff", 16'hFFFF, 16'h0000);
    do_update(16'hFFFF, 16'h0005, 1'b1, 1'b1);
    predict("uncond_ffff", 16'hFFFF, 16'h0005);

    // Same-cycle read/update uses pre-update contents.
    @(negedge clk);
    PC            = 16'h0050;
    update_en     = 1'b1;
    update_PC     = 16'h0050;
    update_target = 16'h0060;
    update_taken  = 1'b1;
    update_uncond = 1'b0;
    #1;
    check_eq("same_cycle_pre", predicted_nextPC, 16'h0051);
    @(posedge clk);
    #1;
    update_en = 1'b0;
    check_eq("same_cycle_post", predicted_nextPC, 16'h0060);

    // Unconditional hit forces strong-taken; one not-taken keeps it taken.
    do_update(16'h0050, 16'h0070, 1'b1, 1'b1);
    predict("uncond_hit_0050", 16'h0050, 16'h0070);
    do_update(16'h0050, 16'h0070, 1'b0, 1'b0);
`ifdef BRANCH_COUNTER_EN
    predict("st_then_nt_0050", 16'h0050, 16'h0070);
`else
    predict("st_then_nt_0050", 16'h0050, 16'h0051);
`endif

    // Mid-RUN reset: everything is invalidated again.
    reset_and_clear("rerun", cyc);
    check_eq("reclear_latency", 16'(cyc), 16'd256);
    predict("post_rst_0120", 16'h0120, 16'h0121);
    predict("post_rst_ffff", 16'hFFFF, 16'h0000);
    predict("post_rst_0050", 16'h0050, 16'h0051);
    predict("post_rst_0030", 16'h0030, 16'h0031);
    check_eq("post_rst_ready", {15'd0, ready}, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
